// File: rtl/lsu_pkg.sv
// Shared types for the 32-bit memory requester: access sizes, FSM states and
// the byte-enable mask for an access size.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    WAIT0,
    GAP,
    REQ1,
    WAIT1,
    DONE,
    ERR
  } req_state_e;

  function automatic logic [3:0] byte_mask(input mem_size_e size);
    case (size)
      SZ_B:    return 4'b0001;
      SZ_H:    return 4'b0011;
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_requester_32_if.sv
// LSU request/response and word-memory bus bundle; master is the requester,
// slave is the LSU pipeline plus memory seen from the other side.
interface mem_requester_32_if;

  logic        req_v;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_adr;
  logic [31:0] req_wdata;
  logic        resp_v;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_r_v;
  logic        mem_w_v;
  logic [31:0] mem_adr;
  logic [31:0] mem_data;
  logic [3:0]  mem_strobe;
  logic [31:0] mem_resp;
  logic        mem_ack;

  modport master (
    input  req_v, req_we, req_size, req_uns, req_adr, req_wdata, mem_resp, mem_ack,
    output req_ready, resp_v, resp_data, resp_err,
           mem_r_v, mem_w_v, mem_adr, mem_data, mem_strobe
  );

  modport slave (
    output req_v, req_we, req_size, req_uns, req_adr, req_wdata, mem_resp, mem_ack,
    input  req_ready, resp_v, resp_data, resp_err,
           mem_r_v, mem_w_v, mem_adr, mem_data, mem_strobe
  );

endinterface

// File: rtl/lsu_align.sv
// Lane steering for the requester: spreads store bytes over a two-word window
// and pulls load bytes back out of it with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  mem_size_e   size,
  input  logic        uns,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] w0,
  input  logic [31:0] w1,
  output logic [3:0]  strobe0,
  output logic [3:0]  strobe1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] rdata
);

  logic [7:0]  strobe64;
  logic [63:0] data64;
  logic [63:0] rd64;
  logic [31:0] raw;

  always_comb begin
    strobe64 = {4'b0000, byte_mask(size)} << off;
    data64   = {32'h0, wdata} << {off, 3'b000};
    rd64     = {w1, w0} >> {off, 3'b000};
    raw      = rd64[31:0];
    strobe0  = strobe64[3:0];
    strobe1  = strobe64[7:4];
    wdata0   = data64[31:0];
    wdata1   = data64[63:32];
    case (size)
      SZ_B:    rdata = uns ? {24'h0, raw[7:0]}   : {{24{raw[7]}}, raw[7:0]};
      SZ_H:    rdata = uns ? {16'h0, raw[15:0]}  : {{16{raw[15]}}, raw[15:0]};
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/mem_requester_32.sv
// Single-outstanding RV32 load/store requester on a 32-bit word memory port,
// splitting word-crossing accesses into two transactions with a timeout guard.
module mem_requester_32
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BASE  = 20000,
  parameter int unsigned MEM_BYTES = 16384,
  parameter int unsigned TIMEOUT   = 64
) (
  input logic                clk,
  input logic                rst,
  mem_requester_32_if.master bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [32:0]     LO_B     = 33'(MEM_BASE);
  localparam logic [32:0]     HI_B     = 33'(MEM_BASE) + 33'(MEM_BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  req_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d, uns_q, uns_d;
  logic [1:0]       size_q, size_d;
  logic [31:0]      adr_q, adr_d, wdata_q, wdata_d, w0_q, w0_d;
  logic             req_ready_q, req_ready_d, resp_v_q, resp_v_d, resp_err_q, resp_err_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic             mem_r_v_q, mem_r_v_d, mem_w_v_q, mem_w_v_d;
  logic [31:0]      mem_adr_q, mem_adr_d, mem_data_q, mem_data_d;
  logic [3:0]       mem_strobe_q, mem_strobe_d;

  logic             idle, accept, split, range_bad;
  logic [32:0]      first_b, last_b;
  logic [1:0]       cur_size;
  logic             cur_uns;
  logic [31:0]      cur_adr, cur_wdata, w0_in;
  logic [3:0]       strobe0, strobe1;
  logic [31:0]      wdata0, wdata1, rdata;

  // The aligner sees the live request while idle and the captured one afterwards.
  always_comb begin
    idle      = (state_q == IDLE);
    accept    = bus.req_v & req_ready_q;
    cur_size  = idle ? bus.req_size  : size_q;
    cur_uns   = idle ? bus.req_uns   : uns_q;
    cur_adr   = idle ? bus.req_adr   : adr_q;
    cur_wdata = idle ? bus.req_wdata : wdata_q;
    w0_in     = (state_q == WAIT0) ? bus.mem_resp : w0_q;
    first_b   = {1'b0, bus.req_adr};
    last_b    = first_b + (33'd1 << bus.req_size) - 33'd1;
    range_bad = (first_b < LO_B) || (last_b >= HI_B);
    split     = |strobe1;
  end

  lsu_align u_align (
    .size    (mem_size_e'(cur_size)),
    .uns     (cur_uns),
    .off     (cur_adr[1:0]),
    .wdata   (cur_wdata),
    .w0      (w0_in),
    .w1      (bus.mem_resp),
    .strobe0 (strobe0),
    .strobe1 (strobe1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .rdata   (rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    uns_d        = uns_q;
    size_d       = size_q;
    adr_d        = adr_q;
    wdata_d      = wdata_q;
    w0_d         = w0_q;
    req_ready_d  = 1'b0;
    resp_v_d     = 1'b0;
    resp_err_d   = 1'b0;
    resp_data_d  = 32'h0;
    mem_r_v_d    = mem_r_v_q;
    mem_w_v_d    = mem_w_v_q;
    mem_adr_d    = mem_adr_q;
    mem_data_d   = mem_data_q;
    mem_strobe_d = mem_strobe_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          req_ready_d = 1'b0;
          we_d        = bus.req_we;
          uns_d       = bus.req_uns;
          size_d      = bus.req_size;
          adr_d       = bus.req_adr;
          wdata_d     = bus.req_wdata;
          if (bus.req_size == 2'd3 || range_bad) begin
            state_d    = ERR;
            resp_v_d   = 1'b1;
            resp_err_d = 1'b1;
          end else begin
            state_d      = REQ0;
            mem_r_v_d    = ~bus.req_we;
            mem_w_v_d    = bus.req_we;
            mem_adr_d    = {bus.req_adr[31:2], 2'b00};
            mem_data_d   = bus.req_we ? wdata0 : 32'h0;
            mem_strobe_d = bus.req_we ? strobe0 : 4'h0;
          end
        end
      end
      REQ0: begin
        state_d = WAIT0;
        cnt_d   = '0;
      end
      WAIT0, WAIT1: begin
        if (bus.mem_ack) begin
          mem_r_v_d    = 1'b0;
          mem_w_v_d    = 1'b0;
          mem_adr_d    = 32'h0;
          mem_data_d   = 32'h0;
          mem_strobe_d = 4'h0;
          if (state_q == WAIT0) w0_d = bus.mem_resp;
          if (state_q == WAIT0 && split) begin
            state_d = GAP;
          end else begin
            state_d     = DONE;
            resp_v_d    = 1'b1;
            resp_data_d = we_q ? 32'h0 : rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          // A silent memory is abandoned; the bus is released before reporting.
          mem_r_v_d    = 1'b0;
          mem_w_v_d    = 1'b0;
          mem_adr_d    = 32'h0;
          mem_data_d   = 32'h0;
          mem_strobe_d = 4'h0;
          state_d      = ERR;
          resp_v_d     = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        state_d      = REQ1;
        mem_r_v_d    = ~we_q;
        mem_w_v_d    = we_q;
        mem_adr_d    = {adr_q[31:2] + 30'd1, 2'b00};
        mem_data_d   = we_q ? wdata1 : 32'h0;
        mem_strobe_d = we_q ? strobe1 : 4'h0;
      end
      REQ1: begin
        state_d = WAIT1;
        cnt_d   = '0;
      end
      DONE, ERR: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'd0;
      adr_q        <= 32'h0;
      wdata_q      <= 32'h0;
      w0_q         <= 32'h0;
      req_ready_q  <= 1'b1;
      resp_v_q     <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= 32'h0;
      mem_r_v_q    <= 1'b0;
      mem_w_v_q    <= 1'b0;
      mem_adr_q    <= 32'h0;
      mem_data_q   <= 32'h0;
      mem_strobe_q <= 4'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      uns_q        <= uns_d;
      size_q       <= size_d;
      adr_q        <= adr_d;
      wdata_q      <= wdata_d;
      w0_q         <= w0_d;
      req_ready_q  <= req_ready_d;
      resp_v_q     <= resp_v_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
      mem_r_v_q    <= mem_r_v_d;
      mem_w_v_q    <= mem_w_v_d;
      mem_adr_q    <= mem_adr_d;
      mem_data_q   <= mem_data_d;
      mem_strobe_q <= mem_strobe_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_v     = resp_v_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.mem_r_v    = mem_r_v_q;
  assign bus.mem_w_v    = mem_w_v_q;
  assign bus.mem_adr    = mem_adr_q;
  assign bus.mem_data   = mem_data_q;
  assign bus.mem_strobe = mem_strobe_q;

endmodule

// File: tb/tb_mem_requester_32.sv
// Directed bench for mem_requester_32: a byte-level request model predicts
// every output cycle, and literal checks pin the headline results.
module tb_mem_requester_32;

  localparam int unsigned MEM_BASE  = 20000;
  localparam int unsigned MEM_BYTES = 16384;
  localparam int unsigned TIMEOUT   = 64;

  typedef struct packed {
    logic        ready;
    logic        rv;
    logic        err;
    logic [31:0] rdata;
    logic        mr;
    logic        mw;
    logic [31:0] madr;
    logic [31:0] mdata;
    logic [3:0]  strb;
  } vec_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
    logic [3:0]  strb;
  } acc_t;

  logic clk;
  logic rst;
  mem_requester_32_if bus ();

  mem_requester_32 #(
    .MEM_BASE  (MEM_BASE),
    .MEM_BYTES (MEM_BYTES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          acceptCyc = 0;
  int          respCyc = 0;
  int          respCount = 0;
  int          respSnap = 0;
  int          wrCount = 0;
  int          wrSnap = 0;
  logic        checkEn = 1'b0;
  logic        muteAck = 1'b0;
  logic        prevValid = 1'b0;
  logic [31:0] lastData = 32'h0;
  logic        lastErr = 1'b0;
  vec_t        expQ[$];
  acc_t        accLog[$];
  vec_t        act, expv, idleVec;
  logic [31:0] memImg [logic [31:0]];

  function automatic logic [7:0] imgByte(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    w  = 32'h0;
    if (memImg.exists(wa)) w = memImg[wa];
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  function automatic acc_t getAcc(input int i);
    acc_t a;
    a = 'x;
    if (i < accLog.size()) a = accLog[i];
    return a;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    tests++;
    if (actual !== required) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
    end
  endtask

  // Predicts the output of every cycle from acceptance to the response.
  task automatic buildExpect(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] adr, input logic [31:0] wdata, input logic mute);
    vec_t        v;
    int          n, o, nw;
    longint      first, last;
    logic [31:0] wa [2];
    logic [3:0]  st [2];
    logic [31:0] dt [2];
    logic [31:0] res;
    n     = 1 << size;
    first = longint'(adr);
    last  = first + longint'(n) - 1;
    v     = '0;
    if (size == 2'd3 || first < longint'(MEM_BASE) ||
        last >= longint'(MEM_BASE) + longint'(MEM_BYTES)) begin
      v.rv  = 1'b1;
      v.err = 1'b1;
      expQ.push_back(v);
      return;
    end
    o  = int'(adr[1:0]);
    nw = (o + n > 4) ? 2 : 1;
    for (int wi = 0; wi < 2; wi++) begin
      wa[wi] = adr - 32'(o) + 32'(4 * wi);
      st[wi] = 4'h0;
      dt[wi] = 32'h0;
    end
    res = 32'h0;
    for (int k = 0; k < n; k++) begin
      int b, wi, lane;
      b    = o + k;
      wi   = b / 4;
      lane = b % 4;
      st[wi][lane]        = 1'b1;
      dt[wi][8*lane +: 8] = wdata[8*k +: 8];
      res[8*k +: 8]       = imgByte(adr + 32'(k));
    end
    if (!uns && res[8*n-1])
      for (int k = n; k < 4; k++) res[8*k +: 8] = 8'hFF;
    for (int wi = 0; wi < nw; wi++) begin
      v       = '0;
      v.mr    = ~we;
      v.mw    = we;
      v.madr  = wa[wi];
      v.mdata = we ? dt[wi] : 32'h0;
      v.strb  = we ? st[wi] : 4'h0;
      repeat (mute ? TIMEOUT + 1 : 2) expQ.push_back(v);
      if (mute) begin
        v     = '0;
        v.rv  = 1'b1;
        v.err = 1'b1;
        expQ.push_back(v);
        return;
      end
      if (wi == 0 && nw == 2) expQ.push_back('0);
    end
    v       = '0;
    v.rv    = 1'b1;
    v.rdata = we ? 32'h0 : res;
    expQ.push_back(v);
  endtask

  task automatic waitDrained();
    for (int i = 0; i < 400 && expQ.size() != 0; i++) @(negedge clk);
    if (expQ.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain_timeout: got %0d pending cycles, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] adr, input logic [31:0] wdata,
                               input logic mute, input int hold);
    waitDrained();
    @(negedge clk);
    muteAck       = mute;
    accLog.delete();
    acceptCyc     = cyc;
    respSnap      = respCount;
    wrSnap        = wrCount;
    bus.req_v     = 1'b1;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_uns   = uns;
    bus.req_adr   = adr;
    bus.req_wdata = wdata;
    buildExpect(we, size, uns, adr, wdata, mute);
    repeat (hold) @(negedge clk);
    bus.req_v = 1'b0;
    waitDrained();
  endtask

  // Memory model: acknowledges any active access unless muted.
  initial begin
    bus.mem_ack  = 1'b0;
    bus.mem_resp = 32'h0;
    forever begin
      @(negedge clk);
      bus.mem_ack  = !muteAck && (bus.mem_r_v || bus.mem_w_v);
      bus.mem_resp = memImg.exists(bus.mem_adr) ? memImg[bus.mem_adr] : 32'h0;
    end
  end

  // Per-cycle monitor and comparison against the predicted output stream.
  initial begin
    idleVec       = '0;
    idleVec.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      act.ready = bus.req_ready;
      act.rv    = bus.resp_v;
      act.err   = bus.resp_err;
      act.rdata = bus.resp_data;
      act.mr    = bus.mem_r_v;
      act.mw    = bus.mem_w_v;
      act.madr  = bus.mem_adr;
      act.mdata = bus.mem_data;
      act.strb  = bus.mem_strobe;
      if (bus.resp_v) begin
        respCount++;
        respCyc  = cyc;
        lastData = bus.resp_data;
        lastErr  = bus.resp_err;
      end
      if ((bus.mem_r_v || bus.mem_w_v) && !prevValid)
        accLog.push_back({bus.mem_adr, bus.mem_data, bus.mem_strobe});
      if (bus.mem_w_v) wrCount++;
      prevValid = bus.mem_r_v || bus.mem_w_v;
      if (checkEn) begin
        expv = (expQ.size() != 0) ? expQ.pop_front() : idleVec;
        tests++;
        if (act !== expv) begin
          fails++;
          $display("[TB] FAIL cycle_compare @%0d: got %h, required %h", cyc, act, expv);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    memImg[MEM_BASE + 8]         = 32'hDEADBEEF;
    memImg[MEM_BASE + 256]       = 32'h80123456;
    memImg[MEM_BASE]             = 32'h44332211;
    memImg[MEM_BASE + 4]         = 32'h88776655;
    memImg[MEM_BASE + MEM_BYTES - 4] = 32'hCAFEF00D;
    bus.req_v     = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd0;
    bus.req_uns   = 1'b0;
    bus.req_adr   = 32'h0;
    bus.req_wdata = 32'h0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    rst     = 1'b0;
    checkEn = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("reset_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("reset_outputs", 32'({bus.resp_v, bus.resp_err, bus.mem_r_v, bus.mem_w_v, bus.mem_strobe}), 32'd0);

    applyStimulus(1'b0, 2'd2, 1'b0, MEM_BASE + 8, 32'h0, 1'b0, 3);
    checkOutput("lw_data", lastData, 32'hDEADBEEF);
    checkOutput("lw_latency", 32'(respCyc - acceptCyc), 32'd3);
    checkOutput("lw_adr", getAcc(0).adr, MEM_BASE + 8);
    checkOutput("lw_one_resp", 32'(respCount - respSnap), 32'd1);

    applyStimulus(1'b0, 2'd0, 1'b0, MEM_BASE + 259, 32'h0, 1'b0, 1);
    checkOutput("lb_signed", lastData, 32'hFFFFFF80);
    applyStimulus(1'b0, 2'd0, 1'b1, MEM_BASE + 259, 32'h0, 1'b0, 1);
    checkOutput("lbu", lastData, 32'h00000080);

    applyStimulus(1'b1, 2'd1, 1'b0, MEM_BASE + 3, 32'h0000ABCD, 1'b0, 1);
    checkOutput("sh_w0_adr", getAcc(0).adr, MEM_BASE);
    checkOutput("sh_w0_strobe", 32'(getAcc(0).strb), 32'h8);
    checkOutput("sh_w0_byte", 32'(getAcc(0).data[31:24]), 32'hCD);
    checkOutput("sh_w1_adr", getAcc(1).adr, MEM_BASE + 4);
    checkOutput("sh_w1_strobe", 32'(getAcc(1).strb), 32'h1);
    checkOutput("sh_w1_byte", 32'(getAcc(1).data[7:0]), 32'hAB);
    checkOutput("sh_latency", 32'(respCyc - acceptCyc), 32'd6);

    applyStimulus(1'b0, 2'd2, 1'b0, MEM_BASE + 2, 32'h0, 1'b0, 1);
    checkOutput("lw_split_data", lastData, 32'h66554433);
    checkOutput("lw_split_latency", 32'(respCyc - acceptCyc), 32'd6);

    applyStimulus(1'b0, 2'd1, 1'b0, MEM_BASE + 6, 32'h0, 1'b0, 1);
    checkOutput("lh_signed", lastData, 32'hFFFF8877);

    applyStimulus(1'b1, 2'd0, 1'b0, MEM_BASE + 5, 32'h0000005A, 1'b0, 1);
    checkOutput("sb_strobe", 32'(getAcc(0).strb), 32'h2);
    checkOutput("sb_data", getAcc(0).data, 32'h00005A00);

    applyStimulus(1'b1, 2'd2, 1'b0, MEM_BASE + MEM_BYTES - 2, 32'h12345678, 1'b0, 1);
    checkOutput("sw_range_err", 32'(lastErr), 32'd1);
    checkOutput("sw_range_no_write", 32'(wrCount - wrSnap), 32'd0);
    checkOutput("sw_range_latency", 32'(respCyc - acceptCyc), 32'd1);

    applyStimulus(1'b0, 2'd3, 1'b0, MEM_BASE, 32'h0, 1'b0, 1);
    checkOutput("size3_err", 32'(lastErr), 32'd1);

    applyStimulus(1'b0, 2'd2, 1'b0, MEM_BASE - 4, 32'h0, 1'b0, 1);
    checkOutput("below_base_err", 32'(lastErr), 32'd1);

    applyStimulus(1'b0, 2'd2, 1'b0, MEM_BASE + MEM_BYTES - 4, 32'h0, 1'b0, 1);
    checkOutput("top_word_ok", 32'(lastErr), 32'd0);
    checkOutput("top_word_data", lastData, 32'hCAFEF00D);

    applyStimulus(1'b0, 2'd2, 1'b0, MEM_BASE + 12, 32'h0, 1'b1, 1);
    checkOutput("timeout_err", 32'(lastErr), 32'd1);
    checkOutput("timeout_latency", 32'(respCyc - acceptCyc), 32'(TIMEOUT + 2));

    // Abort a split load while it waits on its second word.
    waitDrained();
    checkEn = 1'b0;
    @(negedge clk);
    muteAck       = 1'b0;
    respSnap      = respCount;
    bus.req_v     = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd2;
    bus.req_uns   = 1'b0;
    bus.req_adr   = MEM_BASE + 2;
    @(negedge clk);
    bus.req_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("gap_valids_low", 32'({bus.mem_r_v, bus.mem_w_v}), 32'd0);
    muteAck = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("wait1_valid", 32'(bus.mem_r_v), 32'd1);
    checkOutput("wait1_adr", bus.mem_adr, MEM_BASE + 4);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_outputs", 32'({bus.resp_v, bus.mem_r_v, bus.mem_w_v, bus.mem_strobe}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst_adr", bus.mem_adr, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("rst_no_resp", 32'(respCount - respSnap), 32'd0);
    muteAck = 1'b0;
    checkEn = 1'b1;

    applyStimulus(1'b0, 2'd2, 1'b0, MEM_BASE + 8, 32'h0, 1'b0, 1);
    checkOutput("post_rst_lw", lastData, 32'hDEADBEEF);

    waitDrained();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
